// File: rtl/kbd_ctrl_pkg.sv
// Shared PS/2 receiver state encoding and frame constants.
package kbd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        START_BIT_VAL   = 1'b0;
    localparam logic        STOP_BIT_VAL    = 1'b1;

    // Odd parity holds when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [FRAME_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/kbd_ctrl_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizer, falling-edge detect, frame FSM, timeout.
module kbd_ctrl_ps2_rx
    import kbd_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    output logic                       byte_valid_c,
    output logic [FRAME_DATA_BITS-1:0] rx_byte,
    output logic                       frame_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_DATA_BITS) + 1;

    logic [1:0]                 clk_sync;
    logic [1:0]                 data_sync;
    logic                       clk_prev;
    rx_state_e                  state, state_nxt;
    logic [CNT_W-1:0]           bit_cnt, bit_cnt_nxt;
    logic [FRAME_DATA_BITS-1:0] shift_nxt;
    logic                       parity_q, parity_nxt;
    logic [TO_W-1:0]            to_cnt, to_nxt;
    logic                       err_nxt;
    logic                       fall;
    logic                       din;

    assign fall = clk_prev & ~clk_sync[1];
    assign din  = data_sync[1];

    // Synchronizers, edge-detect history and FSM registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_byte   <= '0;
            parity_q  <= 1'b0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            rx_byte   <= shift_nxt;
            parity_q  <= parity_nxt;
            to_cnt    <= to_nxt;
            frame_err <= err_nxt;
        end
    end

    // Frame sequencing on detected PS/2 clock falls, with inter-edge timeout.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = rx_byte;
        parity_nxt   = parity_q;
        to_nxt       = to_cnt;
        err_nxt      = 1'b0;
        byte_valid_c = 1'b0;

        if (state == ST_IDLE) begin
            to_nxt = '0;
            if (fall && din == START_BIT_VAL) begin
                state_nxt   = ST_DATA;
                bit_cnt_nxt = '0;
            end
        end else if (fall) begin
            to_nxt = '0;
            case (state)
                ST_DATA: begin
                    shift_nxt   = {din, rx_byte[FRAME_DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(FRAME_DATA_BITS - 1)) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_nxt = din;
                    state_nxt  = ST_STOP;
                end
                default: begin
                    if (din == STOP_BIT_VAL && odd_parity_ok(rx_byte, parity_q)) begin
                        byte_valid_c = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state_nxt = ST_IDLE;
            to_nxt    = '0;
            err_nxt   = 1'b1;
        end else begin
            to_nxt = to_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/kbd_ctrl.sv
// Keyboard controller: PS/2 receiver feeding a first-word-fall-through byte FIFO.
module kbd_ctrl
    import kbd_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       read_enable,
    output logic       ready,
    output logic [7:0] data,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic       byte_valid_c;
    logic [7:0] rx_byte;
    logic [7:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic       empty_c, full_c, pop_c, push_c, drop_c;
    logic       ready_nxt, ovf_nxt;
    logic [7:0] head_nxt;

    kbd_ctrl_ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .byte_valid_c (byte_valid_c),
        .rx_byte      (rx_byte),
        .frame_err    (frame_err)
    );

    // Pointer arithmetic and the registered view of the next head entry.
    always_comb begin
        empty_c   = (rd_ptr == wr_ptr);
        full_c    = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
        pop_c     = read_enable && !empty_c;
        push_c    = byte_valid_c && (!full_c || pop_c);
        drop_c    = byte_valid_c && full_c && !pop_c;
        rd_nxt    = rd_ptr + PW'(pop_c);
        wr_nxt    = wr_ptr + PW'(push_c);
        ready_nxt = (rd_nxt != wr_nxt);
        head_nxt  = 8'h00;
        if (ready_nxt) begin
            // A byte written this cycle into the new head slot is not yet in mem.
            if (push_c && rd_nxt[AW-1:0] == wr_ptr[AW-1:0]) begin
                head_nxt = rx_byte;
            end else begin
                head_nxt = mem[rd_nxt[AW-1:0]];
            end
        end
        ovf_nxt = overflow;
        if (pop_c) begin
            ovf_nxt = 1'b0;
        end
        if (drop_c) begin
            ovf_nxt = 1'b1;
        end
    end

    // FIFO control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ready    <= 1'b0;
            data     <= 8'h00;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_nxt;
            ready    <= ready_nxt;
            data     <= head_nxt;
            overflow <= ovf_nxt;
        end
    end

    // FIFO storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_kbd_ctrl.sv
// Randomized self-checking bench for kbd_ctrl against a frame-level queue model.
module tb_kbd_ctrl;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 200;
    localparam int          HALF    = 6;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       read_enable;
    logic       ready;
    logic [7:0] data;
    logic       overflow;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;
    int err_run = 0;
    int long_pulse = 0;

    logic [7:0] mq[$];
    logic       m_ovf;

    kbd_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .read_enable (read_enable),
        .ready       (ready),
        .data        (data),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame_err pulses and flag any pulse wider than one cycle.
    always @(posedge clk) begin
        if (frame_err === 1'b1) begin
            err_seen = err_seen + 1;
            err_run  = err_run + 1;
            if (err_run > 1) long_pulse = long_pulse + 1;
        end else begin
            err_run = 0;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_fifo(input string tag);
        logic [7:0] h;
        h = (mq.size() > 0) ? mq[0] : 8'h00;
        chk({tag, ".ready"}, 32'(ready), 32'(mq.size() > 0));
        chk({tag, ".data"}, 32'(data), 32'(h));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    endtask

    function automatic void model_push(input logic [7:0] b);
        if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(b);
    endfunction

    function automatic void model_pop();
        if (mq.size() > 0) begin
            void'(mq.pop_front());
            m_ovf = 1'b0;
        end
    endfunction

    // Bit-bang one PS/2 frame; optionally pulse read_enable to land on the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                              input int nbits, input logic pop_at_stop);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF - 1) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_stop && i == 10) begin
                @(negedge clk);
                @(negedge clk);
                read_enable = 1'b1;
                @(negedge clk);
                read_enable = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input string tag);
        int e0;
        e0 = err_seen;
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
        model_push(b);
        repeat (4) @(negedge clk);
        chk({tag, ".ferr"}, 32'(err_seen - e0), 32'd0);
        check_fifo(tag);
    endtask

    task automatic send_bad(input logic [7:0] b, input logic par_flip, input logic stop_v, input string tag);
        int e0;
        e0 = err_seen;
        send_frame(b, par_flip, stop_v, 11, 1'b0);
        repeat (4) @(negedge clk);
        chk({tag, ".ferr"}, 32'(err_seen - e0), 32'd1);
        check_fifo(tag);
    endtask

    task automatic do_pop(input string tag);
        @(negedge clk);
        read_enable = 1'b1;
        @(negedge clk);
        read_enable = 1'b0;
        model_pop();
        check_fifo(tag);
    endtask

    initial begin
        int e0;
        int r;
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        read_enable = 1'b0;
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ready", 32'(ready), 32'd0);
        chk("reset.data", 32'(data), 32'd0);
        chk("reset.ovf", 32'(overflow), 32'd0);
        chk("reset.ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame then pop.
        send_good(8'h1C, "single");
        chk("single.byte", 32'(data), 32'h1C);
        do_pop("single.pop");

        // Ordering across three frames.
        send_good(8'h1C, "seq0");
        send_good(8'h32, "seq1");
        send_good(8'h21, "seq2");
        for (int i = 0; i < 3; i++) do_pop("seq.pop");
        chk("seq.empty", 32'(ready), 32'd0);

        // Parity and stop-bit errors.
        send_bad(8'h1C, 1'b1, 1'b1, "bad_par");
        send_bad(8'h1C, 1'b0, 1'b0, "bad_stop");

        // Timeout after four data bits, then a clean frame.
        e0 = err_seen;
        send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0);
        repeat (TIMEOUT + 20) @(negedge clk);
        chk("timeout.ferr", 32'(err_seen - e0), 32'd1);
        check_fifo("timeout");
        send_good(8'h5A, "after_to");
        do_pop("after_to.pop");

        // Nine frames into eight entries.
        for (int i = 0; i < 9; i++) send_good(8'(8'h40 + i), "fill");
        chk("fill.ovf", 32'(overflow), 32'd1);
        do_pop("fill.pop");
        chk("fill.head2", 32'(data), 32'h41);
        send_good(8'h77, "refill");
        send_good(8'h78, "drop");

        // Push coinciding with a pop while full.
        e0 = err_seen;
        send_frame(8'hAB, 1'b0, 1'b1, 11, 1'b1);
        void'(mq.pop_front());
        mq.push_back(8'hAB);
        m_ovf = 1'b0;
        repeat (4) @(negedge clk);
        chk("same.ferr", 32'(err_seen - e0), 32'd0);
        check_fifo("same");
        for (int i = 0; i < DEPTH; i++) do_pop("drain");
        chk("drain.empty", 32'(ready), 32'd0);
        do_pop("empty.pop");

        // Randomized mix of good frames, corrupted frames and pops.
        for (int it = 0; it < 60; it++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 5) send_good(8'($urandom), "rnd.good");
            else if (r == 6) send_bad(8'($urandom), 1'b1, 1'b1, "rnd.par");
            else if (r == 7) send_bad(8'($urandom), 1'b0, 1'b0, "rnd.stop");
            else do_pop("rnd.pop");
        end

        // Reset in the middle of a frame with the FIFO occupied.
        send_good(8'h99, "pre_rst");
        e0 = err_seen;
        send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst.ready", 32'(ready), 32'd0);
        chk("midrst.data", 32'(data), 32'd0);
        chk("midrst.ovf", 32'(overflow), 32'd0);
        chk("midrst.ferr", 32'(err_seen - e0), 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        send_good(8'hE5, "post_rst");

        chk("ferr.width", 32'(long_pulse), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
